wave_capture_ctrl: RTL and testbench
====================================

Name: wave_capture_ctrl

Overview:
- Capture controller for the 512-entry double-buffered sample RAM read by the waveform display.
- Arms on a positive-going zero crossing of the audio stream and writes 256 scaled samples into the half not being displayed.
- Waits for the display's end-of-frame strobe, then flips read_index so the display shows the new capture.
- Sits between the codec sample stream and the RAM write port; the display owns the read port.

Parameters:
- SAMPLE_WIDTH, 16, signed input sample width (must be >= 8).
- ADDR_BITS, 8, address bits per buffer half (256 samples).
- ARM_TIMEOUT, 1024, samples seen in ARMED without a crossing before a forced trigger (1..65535).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- new_sample  in  1  one-cycle strobe; sample_in valid this cycle.
- sample_in  in  SAMPLE_WIDTH  two's-complement audio sample.
- frame_done  in  1  one-cycle strobe from the display at end of visible frame.
- write_enable  out  1  RAM write strobe.
- write_address  out  ADDR_BITS+1  RAM write address; MSB selects the buffer half.
- write_sample  out  8  RAM write data, offset-binary.
- read_index  out  1  buffer half the display reads.
- state  out  2  0=ARMED, 1=ACTIVE, 2=WAIT (3 unused).

Behaviour:
- Reset (async assert, sync release): state=ARMED, read_index=0, write_enable=0, write_address=0, write_sample=0, index=0, timeout count=0, prev_neg=0.
- prev_neg <= sample_in MSB on every new_sample in every state.
- crossing = new_sample & prev_neg & ~sample_in MSB. The first sample after reset can never be a crossing.
- Scaling: write_sample = sample_in[SAMPLE_WIDTH-1 -: 8] with its MSB inverted. Examples: -32768 -> 0x00, 0 -> 0x80, 32767 -> 0xFF.
- Writes are registered. write_enable pulses high exactly one cycle, in the cycle after the accepted new_sample. write_address and write_sample update in that same cycle and hold until the next write.
- write_address = {~read_index, index}. The controller never writes the half being displayed.
- ARMED:
  - On crossing: write sample at index 0, index <= 1, go to ACTIVE.
  - Otherwise, on new_sample: timeout count += 1. When the count reaches ARM_TIMEOUT, that sample is a forced trigger (same action as a crossing).
  - Timeout count clears on every entry to ARMED.
- ACTIVE:
  - Each new_sample is written at index, then index increments.
  - The write at index 2^ADDR_BITS-1 moves to WAIT and wraps index to 0.
  - Crossings are ignored.
- WAIT:
  - new_sample produces no write (prev_neg still tracks).
  - On frame_done: read_index toggles in the next cycle, state goes to ARMED.
- frame_done is only honoured in WAIT. A frame_done in the same cycle as the final ACTIVE sample is ignored; the flip waits for the next frame_done.
- new_sample and frame_done together in WAIT: the flip wins and the sample is ignored. That sample still updates prev_neg, so it can pair with the next sample to form the ARMED crossing.
- Reset mid-capture: the partial buffer is abandoned, read_index returns to 0, and the next capture writes half 1.
- Throughput: one sample per cycle is supported. Back-to-back strobes produce back-to-back writes.

Test Plan:
- Reset then samples -100, +50 -> the +50 sample triggers. write_enable pulses one cycle later with write_address=0x100 and write_sample=0x80. state=ACTIVE.
- Ramp of 256 samples after trigger -> writes at 0x100..0x1FF, each one cycle after its strobe. state=WAIT after the 0x1FF write. No write on the 257th strobe.
- In WAIT, pulse frame_done -> read_index=1 next cycle, state=ARMED. The next capture writes 0x000..0x0FF.
- Constant +1000 input for 1024 strobes -> forced trigger on the 1024th strobe, writing address 0x100 with data 0x83.
- frame_done coincident with the final (index 255) strobe -> read_index unchanged. The flip occurs only on the next frame_done.
- Assert reset_n low while at index 100 -> all outputs zero asynchronously and state=ARMED. After release, a crossing writes at 0x100.

Source files
------------

// File: rtl/wave_capture_ctrl.sv
// Capture controller for the double-buffered waveform RAM: arms on a rising zero
// crossing, writes one buffer half of scaled samples, then flips halves on frame end.
`timescale 1ns/1ps

module wave_capture_ctrl #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ADDR_BITS    = 8,
  parameter int ARM_TIMEOUT  = 1024
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    new_sample,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    frame_done,
  output logic                    write_enable,
  output logic [ADDR_BITS:0]      write_address,
  output logic [7:0]              write_sample,
  output logic                    read_index,
  output logic [1:0]              state
);

  typedef enum logic [1:0] {
    S_ARMED  = 2'd0,
    S_ACTIVE = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  localparam logic [15:0]          TIMEOUT_VAL = 16'(ARM_TIMEOUT);
  localparam logic [ADDR_BITS-1:0] LAST_INDEX  = '1;

  state_t                state_q;
  logic [ADDR_BITS-1:0]  index;
  logic [15:0]           timeout_count;
  logic                  prev_neg;

  logic                  sample_neg;
  logic                  crossing;
  logic [15:0]           count_inc;
  logic                  forced;
  logic [7:0]            scaled;

  // Scaling keeps only the top byte of the sample; the remaining bits are dropped.
  generate
    if (SAMPLE_WIDTH > 8) begin : g_lsbs
      logic unused_lsbs;
      assign unused_lsbs = ^sample_in[SAMPLE_WIDTH-9:0];
    end
  endgenerate

  assign sample_neg = sample_in[SAMPLE_WIDTH-1];
  assign crossing   = new_sample & prev_neg & ~sample_neg;
  assign count_inc  = timeout_count + 16'd1;
  assign forced     = new_sample & (count_inc == TIMEOUT_VAL);
  // Offset-binary conversion: invert the sign bit of the top byte.
  assign scaled     = {~sample_in[SAMPLE_WIDTH-1], sample_in[SAMPLE_WIDTH-2 -: 7]};
  assign state      = state_q;

  // NOTE: all state here is updated with non-blocking assignments so every register
  // samples the same pre-edge values; blocking assignments would make order matter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_ARMED;
      read_index    <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_sample  <= '0;
      index         <= '0;
      timeout_count <= '0;
      prev_neg      <= 1'b0;
    end else begin
      // NOTE: defaulting the strobe low at the top makes it a one-cycle pulse and
      // gives every path through the case an assignment.
      write_enable <= 1'b0;

      if (new_sample) begin
        prev_neg <= sample_neg;
      end

      case (state_q)
        S_ARMED: begin
          if (new_sample) begin
            if (crossing || forced) begin
              write_enable  <= 1'b1;
              write_address <= {~read_index, index};
              write_sample  <= scaled;
              index         <= index + 1'b1;
              timeout_count <= '0;
              state_q       <= S_ACTIVE;
            end else begin
              timeout_count <= count_inc;
            end
          end
        end

        S_ACTIVE: begin
          if (new_sample) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, index};
            write_sample  <= scaled;
            // The final write wraps index back to zero for the next capture.
            index         <= index + 1'b1;
            if (index == LAST_INDEX) begin
              state_q <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (frame_done) begin
            read_index    <= ~read_index;
            timeout_count <= '0;
            state_q       <= S_ARMED;
          end
        end

        default: begin
          state_q <= S_ARMED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Directed self-checking bench for wave_capture_ctrl: trigger, fill, flip, timeout,
// coincident strobes and mid-capture reset.
`timescale 1ns/1ps

module tb_wave_capture_ctrl;

  localparam int SW = 16;
  localparam int AB = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          new_sample = 1'b0;
  logic [SW-1:0] sample_in = '0;
  logic          frame_done = 1'b0;
  logic          write_enable;
  logic [AB:0]   write_address;
  logic [7:0]    write_sample;
  logic          read_index;
  logic [1:0]    state;

  int n_cmp = 0;
  int n_err = 0;

  wave_capture_ctrl #(
    .SAMPLE_WIDTH (SW),
    .ADDR_BITS    (AB),
    .ARM_TIMEOUT  (1024)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .new_sample    (new_sample),
    .sample_in     (sample_in),
    .frame_done    (frame_done),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_sample  (write_sample),
    .read_index    (read_index),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one strobe, then return 1ns after the edge that consumed it.
  task automatic strobe(input logic [SW-1:0] v, input logic fd);
    new_sample = 1'b1;
    sample_in  = v;
    frame_done = fd;
    @(posedge clk);
    #1;
    new_sample = 1'b0;
    frame_done = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame_done();
    frame_done = 1'b1;
    idle();
    frame_done = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [AB:0] a, input logic [7:0] d);
    check({tag, "_we"},   32'(write_enable),  32'd1);
    check({tag, "_addr"}, 32'(write_address), 32'(a));
    check({tag, "_data"}, 32'(write_sample),  32'(d));
  endtask

  // Strobes indices 1..255 of a capture. ramp=1 sends (i-128)*256, whose scaled byte is i;
  // ramp=0 sends constant +1000, scaled to 0x83.
  task automatic fill(input logic [AB:0] base, input bit ramp, input logic fd_last);
    logic [SW-1:0] v;
    logic [7:0]    d;
    for (int i = 1; i < 256; i++) begin
      v = ramp ? SW'((i - 128) * 256) : SW'(1000);
      d = ramp ? 8'(i) : 8'h83;
      strobe(v, (i == 255) ? fd_last : 1'b0);
      expect_write("fill", base + (AB+1)'(i), d);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    #12;
    check("rst_we",    32'(write_enable),  32'd0);
    check("rst_addr",  32'(write_address), 32'd0);
    check("rst_data",  32'(write_sample),  32'd0);
    check("rst_ridx",  32'(read_index),    32'd0);
    check("rst_state", 32'(state),         32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // -100 then +50 -> crossing on +50.
    strobe(-SW'(100), 1'b0);
    check("neg_no_we", 32'(write_enable), 32'd0);
    strobe(SW'(50), 1'b0);
    expect_write("trig", 9'h100, 8'h80);
    check("trig_state", 32'(state), 32'd1);
    idle();
    check("pulse_we",    32'(write_enable),  32'd0);
    check("hold_addr",   32'(write_address), 32'h100);

    // Remainder of the first capture into half 1.
    fill(9'h100, 1'b1, 1'b0);
    check("fill1_state", 32'(state), 32'd2);
    strobe(-SW'(5), 1'b0);
    check("wait_no_we",   32'(write_enable), 32'd0);
    check("wait_state",   32'(state),        32'd2);

    // Flip, then second capture into half 0 with frame_done on its last strobe.
    pulse_frame_done();
    check("flip_ridx",  32'(read_index), 32'd1);
    check("flip_state", 32'(state),      32'd0);
    strobe(SW'(7), 1'b0);
    expect_write("cap2", 9'h000, 8'h80);
    fill(9'h000, 1'b1, 1'b1);
    check("coinc_ridx",  32'(read_index), 32'd1);
    check("coinc_state", 32'(state),      32'd2);
    idle();
    check("coinc_ridx2", 32'(read_index), 32'd1);
    pulse_frame_done();
    check("flip2_ridx",  32'(read_index), 32'd0);
    check("flip2_state", 32'(state),      32'd0);

    // Constant +1000: forced trigger on the 1024th strobe.
    for (int j = 1; j < 1024; j++) begin
      strobe(SW'(1000), 1'b0);
      check("armed_no_we", 32'(write_enable), 32'd0);
    end
    check("pre_force_state", 32'(state), 32'd0);
    strobe(SW'(1000), 1'b0);
    expect_write("force", 9'h100, 8'h83);
    check("force_state", 32'(state), 32'd1);
    fill(9'h100, 1'b0, 1'b0);
    check("fill3_state", 32'(state), 32'd2);

    // Sample and frame_done together in WAIT: flip wins, sample arms the next crossing.
    strobe(-SW'(1), 1'b1);
    check("both_no_we", 32'(write_enable), 32'd0);
    check("both_ridx",  32'(read_index),   32'd1);
    check("both_state", 32'(state),        32'd0);
    strobe(SW'(1), 1'b0);
    expect_write("pair", 9'h000, 8'h80);

    // Reset mid-capture at index 100.
    for (int k = 1; k < 100; k++) strobe(SW'(1000), 1'b0);
    check("mid_addr", 32'(write_address), 32'h063);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_we",    32'(write_enable),  32'd0);
    check("arst_addr",  32'(write_address), 32'd0);
    check("arst_data",  32'(write_sample),  32'd0);
    check("arst_ridx",  32'(read_index),    32'd0);
    check("arst_state", 32'(state),         32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    strobe(-SW'(1), 1'b0);
    check("post_rst_no_we", 32'(write_enable), 32'd0);
    strobe(SW'(1), 1'b0);
    expect_write("post_rst", 9'h100, 8'h80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
